// File: rtl/if_stage_pkg.sv
// Shared definitions for the miniRV instruction-fetch stage.
package if_stage_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IF_BOOT = 2'd0,
        IF_RUN  = 2'd1,
        IF_HALT = 2'd2
    } if_state_e;

    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: bubble beats hold, hold beats a fresh load.
import if_stage_pkg::*;

module if_id_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        bubble,
    input  logic [31:0] ld_pc,
    input  logic [31:0] ld_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [31:0] id_inst,
    output logic        id_valid
);

    logic [31:0] id_pc_r;
    logic [31:0] id_pc4_r;
    logic [31:0] id_inst_r;
    logic        id_valid_r;

    // Slot update: reset, bubble insertion, hold, or capture of the fetched word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_pc_r    <= 32'h0000_0000;
            id_pc4_r   <= 32'h0000_0000;
            id_inst_r  <= NOP_INST;
            id_valid_r <= 1'b0;
        end else if (bubble) begin
            id_pc_r    <= 32'h0000_0000;
            id_pc4_r   <= 32'h0000_0000;
            id_inst_r  <= NOP_INST;
            id_valid_r <= 1'b0;
        end else if (hold) begin
            id_pc_r    <= id_pc_r;
            id_pc4_r   <= id_pc4_r;
            id_inst_r  <= id_inst_r;
            id_valid_r <= id_valid_r;
        end else begin
            id_pc_r    <= ld_pc;
            id_pc4_r   <= ld_pc + 32'd4;
            id_inst_r  <= ld_inst;
            id_valid_r <= 1'b1;
        end
    end

    assign id_pc    = id_pc_r;
    assign id_pc4   = id_pc4_r;
    assign id_inst  = id_inst_r;
    assign id_valid = id_valid_r;

endmodule

// File: rtl/if_stage.sv
// miniRV fetch stage: PC register, BOOT/RUN/HALT fetch FSM, perf counters, IF/ID slot.
import if_stage_pkg::*;

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IROM_AW  = 14,
    parameter int          CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        npc,
    input  logic               stall,
    input  logic               flush,
    input  logic               halt_req,
    input  logic [31:0]        irom_inst,
    output logic [31:0]        pc,
    output logic [IROM_AW-1:0] irom_addr,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_pc4,
    output logic [31:0]        id_inst,
    output logic               id_valid,
    output logic               misalign,
    output logic [CNT_W-1:0]   fetch_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    if_state_e        state_r;
    logic [31:0]      pc_r;
    logic             misalign_r;
    logic [CNT_W-1:0] fetch_cnt_r;
    logic [CNT_W-1:0] bubble_cnt_r;
    logic             bubble_s;
    logic             hold_s;
    logic             npc_mis_s;

    assign npc_mis_s = (npc[1:0] != 2'b00);

    // IF/ID control; a flush also kills a same-cycle halt because the halting insn is younger
    always_comb begin
        bubble_s = 1'b1;
        hold_s   = 1'b0;
        if (state_r == IF_RUN) begin
            bubble_s = flush | halt_req;
            hold_s   = stall & ~flush & ~halt_req;
        end else begin
            bubble_s = 1'b1;
            hold_s   = 1'b0;
        end
    end

    // PC, fetch FSM, sticky misalign flag and perf counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IF_BOOT;
            pc_r         <= RESET_PC;
            misalign_r   <= 1'b0;
            fetch_cnt_r  <= {CNT_W{1'b0}};
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IF_BOOT: begin
                    state_r <= IF_RUN;
                end
                IF_RUN: begin
                    if (flush) begin
                        pc_r         <= align_pc(npc);
                        misalign_r   <= misalign_r | npc_mis_s;
                        bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
                    end else if (halt_req) begin
                        state_r <= IF_HALT;
                    end else if (stall) begin
                        bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
                    end else begin
                        pc_r        <= align_pc(npc);
                        misalign_r  <= misalign_r | npc_mis_s;
                        fetch_cnt_r <= fetch_cnt_r + CNT_ONE;
                    end
                end
                IF_HALT: begin
                    state_r <= IF_HALT;
                end
                default: begin
                    state_r <= IF_BOOT;
                end
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (hold_s),
        .bubble   (bubble_s),
        .ld_pc    (pc_r),
        .ld_inst  (irom_inst),
        .id_pc    (id_pc),
        .id_pc4   (id_pc4),
        .id_inst  (id_inst),
        .id_valid (id_valid)
    );

    assign pc         = pc_r;
    assign irom_addr  = pc_r[IROM_AW+1:2];
    assign misalign   = misalign_r;
    assign fetch_cnt  = fetch_cnt_r;
    assign bubble_cnt = bubble_cnt_r;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected IF/ID contents are queued per cycle, a negedge monitor pops them.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] npc;
    logic        stall;
    logic        flush;
    logic        halt_req;
    logic [31:0] irom_inst;
    logic [31:0] pc;
    logic [13:0] irom_addr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        misalign;
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;

    int n_pass  = 0;
    int n_total = 0;
    logic [95:0] exp_q[$];

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .IROM_AW  (14),
        .CNT_W    (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .npc        (npc),
        .stall      (stall),
        .flush      (flush),
        .halt_req   (halt_req),
        .irom_inst  (irom_inst),
        .pc         (pc),
        .irom_addr  (irom_addr),
        .id_pc      (id_pc),
        .id_pc4     (id_pc4),
        .id_inst    (id_inst),
        .id_valid   (id_valid),
        .misalign   (misalign),
        .fetch_cnt  (fetch_cnt),
        .bubble_cnt (bubble_cnt)
    );

    function automatic logic [31:0] rom_word(input logic [13:0] a);
        return 32'hC000_0000 | {18'd0, a};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb irom_inst = rom_word(irom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One cycle: drive inputs, queue the IF/ID word expected after the next edge, advance.
    task automatic cyc(input logic [31:0] n, input logic s, input logic f, input logic h,
                       input logic pv, input logic [31:0] epc);
        npc = n; stall = s; flush = f; halt_req = h;
        if (pv) exp_q.push_back({epc, epc + 32'd4, rom_word(epc[15:2])});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (id_valid === 1'b1) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL ifid_unexpected: got pc=%h inst=%h, no slot expected", id_pc, id_inst);
            end else begin
                logic [95:0] e;
                e = exp_q.pop_front();
                if ({id_pc, id_pc4, id_inst} === e) n_pass++;
                else $display("FAIL ifid_slot: got %h/%h/%h expected %h/%h/%h",
                              id_pc, id_pc4, id_inst, e[95:64], e[63:32], e[31:0]);
            end
        end
    end

    initial begin
        rst_n = 1'b0; npc = 32'h0; stall = 1'b0; flush = 1'b0; halt_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_pc", pc, 32'h0);
        chk("reset_valid", {31'd0, id_valid}, 32'h0);
        chk("reset_inst", id_inst, 32'h0000_0013);
        chk("reset_cnts", fetch_cnt | bubble_cnt, 32'h0);
        rst_n = 1'b1;

        // BOOT cycle: pc held, bubble
        cyc(32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("boot_pc", pc, 32'h0);
        chk("boot_valid", {31'd0, id_valid}, 32'h0);

        for (int i = 0; i < 4; i++) cyc(32'(4 * (i + 1)), 1'b0, 1'b0, 1'b0, 1'b1, 32'(4 * i));
        chk("seq_pc_mid", pc, 32'h10);

        for (int i = 0; i < 3; i++) cyc(32'h14, 1'b1, 1'b0, 1'b0, 1'b1, 32'hC);
        chk("stall_pc", pc, 32'h10);
        chk("stall_bubbles", bubble_cnt, 32'd3);
        chk("stall_fetch", fetch_cnt, 32'd4);

        cyc(32'h14, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10);
        cyc(32'h18, 1'b0, 1'b0, 1'b0, 1'b1, 32'h14);
        cyc(32'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 32'h18);
        cyc(32'h20, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1C);
        chk("seq_pc", pc, 32'h20);
        chk("seq_fetch", fetch_cnt, 32'd8);

        cyc(32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("flush_pc", pc, 32'h100);
        chk("flush_valid", {31'd0, id_valid}, 32'h0);
        chk("flush_bubbles", bubble_cnt, 32'd4);
        cyc(32'h104, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100);

        chk("misalign_clear", {31'd0, misalign}, 32'h0);
        cyc(32'h102, 1'b0, 1'b0, 1'b0, 1'b1, 32'h104);
        chk("misalign_pc", pc, 32'h100);
        chk("misalign_set", {31'd0, misalign}, 32'h1);
        cyc(32'h104, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
        chk("misalign_sticky", {31'd0, misalign}, 32'h1);

        // pc+4 wraps at the top of the address space
        cyc(32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("wrap_irom_addr", {18'd0, irom_addr}, 32'h3FFF);
        cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_pc", pc, 32'h0);

        // Flush outranks halt_req: stage keeps running
        cyc(32'h200, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        cyc(32'h204, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
        chk("flushhalt_pc", pc, 32'h204);
        chk("flushhalt_fetch", fetch_cnt, 32'd13);

        cyc(32'h300, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++)
            cyc(32'h400 + 32'(i * 4), i[0], i[1], 1'b0, 1'b0, 32'h0);
        chk("halt_pc", pc, 32'h204);
        chk("halt_fetch", fetch_cnt, 32'd13);
        chk("halt_bubbles", bubble_cnt, 32'd6);
        chk("halt_valid", {31'd0, id_valid}, 32'h0);

        rst_n = 1'b0;
        cyc(32'h500, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("rereset_pc", pc, 32'h0);
        chk("rereset_misalign", {31'd0, misalign}, 32'h0);
        chk("rereset_cnts", fetch_cnt | bubble_cnt, 32'h0);
        rst_n = 1'b1;

        // BOOT ignores flush/halt_req, then fetches from RESET_PC
        cyc(32'h500, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("boot_ignore_pc", pc, 32'h0);
        cyc(32'h4, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("boot_run_pc", pc, 32'h4);

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
